// File: rtl/toggle_event_receiver.sv
// toggle_event_receiver
//
// Receiving end of a toggle-encoded event link. The remote side inverts
// toggle_in once per event. This block synchronizes that level, turns every
// level change into a one-cycle strobe, and buffers the events in a
// saturating counter. The consumer drains the counter one event per
// valid/ready transfer.
//
// Parameters:
//   SYNC_STAGES    synchronizer depth on toggle_in (2 or more)
//   COUNTER_WIDTH  pending-event counter width; holds up to 2^W-1 events
//
// Ports:
//   clock          single clock for all logic
//   reset          asynchronous, active-high reset
//   toggle_in      toggle-encoded event level (may be asynchronous)
//   clear          synchronous clear of pending events and overflow
//   event_pulse    one-cycle strobe per detected toggle_in transition
//   event_valid    at least one event is pending
//   event_ready    consumer takes one event when high together with event_valid
//   pending_count  number of pending events
//   overflow       sticky; an event was dropped because the counter was full

module toggle_event_receiver #(
    parameter int SYNC_STAGES   = 2,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     toggle_in,
    input  logic                     clear,
    output logic                     event_pulse,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic [COUNTER_WIDTH-1:0] pending_count,
    output logic                     overflow
);

    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     level_q;
    logic [COUNTER_WIDTH-1:0] count_q;
    logic                     overflow_q;

    logic inc;
    logic dec;

    // Synchronizer chain plus the level register holding the previous value
    // of the last stage. Clearing the chain to 0 matches a transmitter that
    // also resets to 0, so no spurious event appears at reset release.
    // NOTE: every register here is written with <= so all flops sample the
    // values from before the edge; blocking assignments would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], toggle_in};
            level_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Any difference between the last stage and its delayed copy is one
    // transition of the remote toggle flop, i.e. one event.
    assign event_pulse = sync_q[SYNC_STAGES-1] ^ level_q;

    assign inc = event_pulse;
    assign dec = event_valid & event_ready;

    // Pending-event counter. clear wins over everything; a simultaneous
    // arrival and transfer cancel out, so nothing is dropped even when full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (inc && !dec) begin
            if (count_q != COUNT_MAX) begin
                count_q <= count_q + COUNT_ONE;
            end else begin
                overflow_q <= 1'b1;
            end
        end else if (dec && !inc) begin
            // dec implies event_valid, so count_q is non-zero here.
            count_q <= count_q - COUNT_ONE;
        end
    end

    assign pending_count = count_q;
    assign event_valid   = (count_q != '0);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Self-checking bench for toggle_event_receiver.
// The reference model keeps the full history of toggle_in samples and
// derives the expected strobe from the transition that reached the end of
// the synchronizer delay; pending events are tracked as a plain integer.

module tb_toggle_event_receiver;

    localparam int SYNC_STAGES   = 2;
    localparam int COUNTER_WIDTH = 4;
    localparam int CAPACITY      = (1 << COUNTER_WIDTH) - 1;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     toggle_in;
    logic                     clear;
    logic                     event_pulse;
    logic                     event_valid;
    logic                     event_ready;
    logic [COUNTER_WIDTH-1:0] pending_count;
    logic                     overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit samples[$];
    int m_count;
    bit m_overflow;
    bit m_pulse;

    toggle_event_receiver #(
        .SYNC_STAGES  (SYNC_STAGES),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .toggle_in    (toggle_in),
        .clear        (clear),
        .event_pulse  (event_pulse),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .pending_count(pending_count),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit sample_at(int i);
        return (i < 0) ? 1'b0 : samples[i];
    endfunction

    function automatic void model_reset();
        samples.delete();
        m_count    = 0;
        m_overflow = 1'b0;
        m_pulse    = 1'b0;
    endfunction

    // One clock edge of the reference model, using inputs as seen at the edge.
    function automatic void model_edge();
        bit inc;
        bit dec;
        int n;
        inc = m_pulse;
        dec = (m_count != 0) && event_ready;
        if (clear) begin
            m_count    = 0;
            m_overflow = 1'b0;
        end else if (inc && !dec) begin
            if (m_count < CAPACITY) m_count++;
            else m_overflow = 1'b1;
        end else if (dec && !inc) begin
            m_count--;
        end
        samples.push_back(toggle_in);
        n = samples.size() - 1;
        // A transition recorded between samples n-S and n-S+1 is visible now.
        m_pulse = sample_at(n - SYNC_STAGES + 1) ^ sample_at(n - SYNC_STAGES);
    endfunction

    task automatic compare_model();
        check("event_pulse",   32'(event_pulse),   32'(m_pulse));
        check("pending_count", 32'(pending_count), 32'(m_count));
        check("event_valid",   32'(event_valid),   32'(m_count != 0));
        check("overflow",      32'(overflow),      32'(m_overflow));
    endtask

    // Advance one cycle; inputs change only around the falling edge.
    task automatic step();
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
        compare_model();
    endtask

    task automatic toggle_wait(input int cycles);
        toggle_in = ~toggle_in;
        repeat (cycles) step();
    endtask

    initial begin
        reset       = 1'b1;
        toggle_in   = 1'b0;
        clear       = 1'b0;
        event_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_pulse", 32'(event_pulse),   32'd0);
        check("reset_valid", 32'(event_valid),   32'd0);
        check("reset_count", 32'(pending_count), 32'd0);
        check("reset_ovf",   32'(overflow),      32'd0);
        reset = 1'b0;
        repeat (3) step();

        // 1. Single toggle: strobe one cycle after the sampling edge's successor
        toggle_in = 1'b1;
        step();
        check("t1_pulse_early", 32'(event_pulse), 32'd0);
        step();
        check("t1_pulse_high", 32'(event_pulse), 32'd1);
        step();
        check("t1_pulse_low", 32'(event_pulse), 32'd0);
        check("t1_count", 32'(pending_count), 32'd1);
        check("t1_valid", 32'(event_valid), 32'd1);
        repeat (3) step();
        check("t1_hold", 32'(pending_count), 32'd1);
        event_ready = 1'b1;
        step();
        event_ready = 1'b0;
        check("t1_drained", 32'(pending_count), 32'd0);
        check("t1_valid_low", 32'(event_valid), 32'd0);

        // 2. Burst accumulate then drain back-to-back
        for (int i = 0; i < 5; i++) toggle_wait(4);
        check("t2_count5", 32'(pending_count), 32'd5);
        event_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_drain", 32'(pending_count), 32'(4 - i));
        end
        event_ready = 1'b0;
        check("t2_ovf", 32'(overflow), 32'd0);

        // 3. Saturation with 17 events
        for (int i = 0; i < 17; i++) begin
            toggle_wait(4);
            if (i == 14) check("t3_full_no_ovf", 32'(overflow), 32'd0);
            if (i >= 15) begin
                check("t3_sat_count", 32'(pending_count), 32'(CAPACITY));
                check("t3_sat_ovf", 32'(overflow), 32'd1);
            end
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t3_clr_count", 32'(pending_count), 32'd0);
        check("t3_clr_ovf", 32'(overflow), 32'd0);

        // 4. Arrival and transfer on the same edge while full
        for (int i = 0; i < CAPACITY; i++) toggle_wait(4);
        toggle_in = ~toggle_in;
        step();
        step();
        check("t4_pulse", 32'(event_pulse), 32'd1);
        event_ready = 1'b1;
        step();
        event_ready = 1'b0;
        check("t4_count", 32'(pending_count), 32'(CAPACITY));
        check("t4_ovf", 32'(overflow), 32'd0);

        // 5. Asynchronous reset mid-operation with an event in flight
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) toggle_wait(4);
        check("t5_count3", 32'(pending_count), 32'd3);
        toggle_in = ~toggle_in;
        step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t5_rst_pulse", 32'(event_pulse), 32'd0);
        check("t5_rst_valid", 32'(event_valid), 32'd0);
        check("t5_rst_count", 32'(pending_count), 32'd0);
        toggle_in = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) step();
        check("t5_one_event", 32'(pending_count), 32'd1);

        // 6. Random soak against the model
        begin
            int gap;
            gap = 0;
            for (int cyc = 0; cyc < 1000; cyc++) begin
                if (gap == 0) begin
                    toggle_in = ~toggle_in;
                    gap = int'($urandom_range(8, SYNC_STAGES + 1));
                end
                gap--;
                event_ready = ($urandom_range(99, 0) < 30);
                clear       = ($urandom_range(99, 0) < 2);
                step();
            end
            clear       = 1'b0;
            event_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
